// File: rtl/uart_fifo_bridge_if.sv
// Signal bundle between the CPU register bus, the bridge and the uartx2 byte port.
// The slave modport is the bridge's view; master is the environment driving it.
interface uart_fifo_bridge_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  cpu_wr;
  logic [7:0]            cpu_wr_data;
  logic                  cpu_rd;
  logic [7:0]            cpu_rd_data;
  logic [4:0]            cpu_rd_status;
  logic                  tx_full;
  logic [DEPTH_LOG2:0]   tx_count;
  logic                  rx_empty;
  logic [DEPTH_LOG2:0]   rx_count;
  logic                  tx_overflow;
  logic                  rx_underflow;
  logic                  clr_errors;

  // Handshake: cpu_wr/cpu_rd are single-cycle requests accepted only when the
  // FIFO has room/data; uart_write_tx fires only after uart_tx_empty was seen
  // high, uart_read_rx only after uart_rx_valid was seen high, and both are
  // exactly one cycle wide with at least two idle cycles between pulses.
  logic [7:0]            uart_txdata;
  logic                  uart_write_tx;
  logic                  uart_tx_empty;
  logic [7:0]            uart_rxdata;
  logic                  uart_rx_valid;
  logic [7:0]            uart_status;
  logic                  uart_read_rx;

  modport slave (
    input  cpu_wr, cpu_wr_data, cpu_rd, clr_errors,
    input  uart_tx_empty, uart_rxdata, uart_rx_valid, uart_status,
    output cpu_rd_data, cpu_rd_status, tx_full, tx_count, rx_empty, rx_count,
    output tx_overflow, rx_underflow, uart_txdata, uart_write_tx, uart_read_rx
  );

  modport master (
    output cpu_wr, cpu_wr_data, cpu_rd, clr_errors,
    output uart_tx_empty, uart_rxdata, uart_rx_valid, uart_status,
    input  cpu_rd_data, cpu_rd_status, tx_full, tx_count, rx_empty, rx_count,
    input  tx_overflow, rx_underflow, uart_txdata, uart_write_tx, uart_read_rx
  );
endinterface

// File: rtl/uart_fifo_bridge.sv
// TX/RX byte FIFOs between the CPU bus and uartx2, each with a small strobe FSM
// that paces uart_write_tx / uart_read_rx to the UART's one-cycle status lag.
module uart_fifo_bridge #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_fifo_bridge_if.slave     bus,
  output logic [1:0]            tx_fsm_state,
  output logic [1:0]            rx_fsm_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // ---------------- TX path ----------------
  logic [7:0]            tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [DEPTH_LOG2:0]   tx_cnt;
  logic                  tx_push, tx_pop, tx_launch;
  logic                  tx_ovf;
  logic                  write_strobe;
  logic [7:0]            tx_byte;
  state_e                tx_state, tx_state_next;

  assign tx_push = bus.cpu_wr && (tx_cnt != FULL_CNT);
  assign tx_pop  = tx_launch;

  always_comb begin
    tx_state_next = tx_state;
    tx_launch     = 1'b0;
    case (tx_state)
      ST_IDLE: begin
        if ((tx_cnt != '0) && bus.uart_tx_empty) begin
          tx_launch     = 1'b1;
          tx_state_next = ST_ACK;
        end
      end
      ST_ACK:  tx_state_next = ST_WAIT;
      ST_WAIT: tx_state_next = ST_IDLE;
      default: tx_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.cpu_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state     <= ST_IDLE;
      tx_wr_ptr    <= '0;
      tx_rd_ptr    <= '0;
      tx_cnt       <= '0;
      tx_ovf       <= 1'b0;
      write_strobe <= 1'b0;
      tx_byte      <= '0;
    end else begin
      tx_state     <= tx_state_next;
      write_strobe <= tx_launch;
      if (tx_launch) tx_byte <= tx_mem[tx_rd_ptr];
      if (tx_push)   tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)    tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
        2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
        default: ;
      endcase
      // A fresh error outranks a same-cycle clear.
      if (bus.cpu_wr && (tx_cnt == FULL_CNT)) tx_ovf <= 1'b1;
      else if (bus.clr_errors)                tx_ovf <= 1'b0;
    end
  end

  // ---------------- RX path ----------------
  logic [12:0]           rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [DEPTH_LOG2:0]   rx_cnt;
  logic                  rx_push, rx_pop, rx_capture;
  logic                  rx_udf;
  logic                  read_strobe;
  logic [12:0]           rx_head;
  logic                  status_unused;
  state_e                rx_state, rx_state_next;

  assign rx_push       = rx_capture;
  assign rx_pop        = bus.cpu_rd && (rx_cnt != '0);
  assign rx_head       = rx_mem[rx_rd_ptr];
  assign status_unused = ^{bus.uart_status[7], bus.uart_status[1:0]};

  // Full check uses the pre-pop count, so a byte is never captured in the
  // same cycle the CPU frees the last slot.
  always_comb begin
    rx_state_next = rx_state;
    rx_capture    = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        if (bus.uart_rx_valid && (rx_cnt != FULL_CNT)) begin
          rx_capture    = 1'b1;
          rx_state_next = ST_ACK;
        end
      end
      ST_ACK:  rx_state_next = ST_WAIT;
      ST_WAIT: rx_state_next = ST_IDLE;
      default: rx_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= {bus.uart_status[6:2], bus.uart_rxdata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state    <= ST_IDLE;
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_cnt      <= '0;
      rx_udf      <= 1'b0;
      read_strobe <= 1'b0;
    end else begin
      rx_state    <= rx_state_next;
      read_strobe <= rx_capture;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CNT_ONE;
        2'b01:   rx_cnt <= rx_cnt - CNT_ONE;
        default: ;
      endcase
      if (bus.cpu_rd && (rx_cnt == '0)) rx_udf <= 1'b1;
      else if (bus.clr_errors)          rx_udf <= 1'b0;
    end
  end

  // ---------------- outputs ----------------
  assign bus.tx_count      = tx_cnt;
  assign bus.tx_full       = (tx_cnt == FULL_CNT);
  assign bus.tx_overflow   = tx_ovf;
  assign bus.uart_txdata   = tx_byte;
  assign bus.uart_write_tx = write_strobe;
  assign bus.rx_count      = rx_cnt;
  assign bus.rx_empty      = (rx_cnt == '0);
  assign bus.rx_underflow  = rx_udf;
  assign bus.uart_read_rx  = read_strobe;
  assign bus.cpu_rd_data   = rx_head[7:0];
  assign bus.cpu_rd_status = rx_head[12:8];
  assign tx_fsm_state      = tx_state;
  assign rx_fsm_state      = rx_state;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge: reset values, TX ordering/pacing,
// overflow/underflow flags, RX capture table, RX full back-pressure, mid-strobe reset.
module tb_uart_fifo_bridge;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] tx_fsm_state, rx_fsm_state;

  uart_fifo_bridge_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  uart_fifo_bridge #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .tx_fsm_state (tx_fsm_state),
    .rx_fsm_state (rx_fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_exp_q[$];

  typedef struct {
    logic [7:0] rxdata;
    logic [7:0] status;
    logic [7:0] exp_data;
    logic [4:0] exp_status;
  } rx_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // TX scoreboard: every strobe must carry the next expected byte, be one
  // cycle wide and be at least 3 cycles after the previous one.
  int   strobe_count = 0;
  int   cycle_no     = 0;
  int   last_strobe  = -1000;
  logic prev_write   = 1'b0;

  always @(negedge clk) begin
    cycle_no++;
    if (bus.uart_write_tx === 1'b1) begin
      strobe_count++;
      check("write_tx_width", prev_write, 0);
      check("write_tx_spacing", (cycle_no - last_strobe) >= 3, 1);
      last_strobe = cycle_no;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL tx_unexpected: got byte 0x%0h with no byte expected", bus.uart_txdata);
      end else begin
        check("tx_data", bus.uart_txdata, exp_q.pop_front());
      end
    end
    prev_write = bus.uart_write_tx;
  end

  task automatic wait_tx_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.tx_count == 0 && tx_fsm_state == 2'd0 && !bus.uart_write_tx) break;
      tick();
    end
    check("tx_drain_count", bus.tx_count, 0);
    check("tx_drain_state", tx_fsm_state, 0);
    check("tx_drain_queue", exp_q.size(), 0);
  endtask

  rx_vec_t rx_vecs[6];
  int      base;
  int      seen;
  logic [7:0] next_rx;

  initial begin
    rx_vecs[0] = '{8'h5A, 8'h14, 8'h5A, 5'b00101};
    rx_vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 5'b11111};
    rx_vecs[2] = '{8'h00, 8'h80, 8'h00, 5'b00000};
    rx_vecs[3] = '{8'hC3, 8'h7C, 8'hC3, 5'b11111};
    rx_vecs[4] = '{8'h3C, 8'h41, 8'h3C, 5'b10000};
    rx_vecs[5] = '{8'h81, 8'h08, 8'h81, 5'b00010};

    reset = 1'b1;
    bus.cpu_wr = 0; bus.cpu_wr_data = 0; bus.cpu_rd = 0; bus.clr_errors = 0;
    bus.uart_tx_empty = 0; bus.uart_rxdata = 0; bus.uart_rx_valid = 0; bus.uart_status = 0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_tx_count", bus.tx_count, 0);
    check("rst_rx_count", bus.rx_count, 0);
    check("rst_rx_empty", bus.rx_empty, 1);
    check("rst_tx_full", bus.tx_full, 0);
    check("rst_tx_overflow", bus.tx_overflow, 0);
    check("rst_rx_underflow", bus.rx_underflow, 0);
    check("rst_write_tx", bus.uart_write_tx, 0);
    check("rst_read_rx", bus.uart_read_rx, 0);
    check("rst_txdata", bus.uart_txdata, 0);
    check("rst_fsm_states", {tx_fsm_state, rx_fsm_state}, 0);

    // TX: three back-to-back pushes with the UART idle
    bus.uart_tx_empty = 1;
    base = strobe_count;
    bus.cpu_wr = 1; bus.cpu_wr_data = 8'h11; exp_q.push_back(8'h11);
    tick();
    check("tx_lat_no_strobe_yet", bus.uart_write_tx, 0);
    check("tx_count_after_push1", bus.tx_count, 1);
    bus.cpu_wr_data = 8'h22; exp_q.push_back(8'h22);
    tick();
    check("tx_lat_strobe", bus.uart_write_tx, 1);
    check("tx_lat_data", bus.uart_txdata, 8'h11);
    check("tx_count_push_pop", bus.tx_count, 1);
    bus.cpu_wr_data = 8'h33; exp_q.push_back(8'h33);
    tick();
    bus.cpu_wr = 0;
    check("tx_count_after_push3", bus.tx_count, 2);
    wait_tx_drain(30);
    check("tx_three_strobes", strobe_count - base, 3);

    // TX: fill to full with the UART busy, then one overflowing push
    bus.uart_tx_empty = 0;
    base = strobe_count;
    for (int i = 0; i < DEPTH; i++) begin
      bus.cpu_wr = 1; bus.cpu_wr_data = 8'(8'h30 + i);
      exp_q.push_back(8'(8'h30 + i));
      tick();
    end
    bus.cpu_wr_data = 8'hAA;
    tick();
    bus.cpu_wr = 0;
    check("tx_full_flag", bus.tx_full, 1);
    check("tx_full_count", bus.tx_count, 16);
    check("tx_overflow_set", bus.tx_overflow, 1);
    check("tx_busy_no_strobe", strobe_count - base, 0);
    bus.uart_tx_empty = 1;
    wait_tx_drain(80);
    check("tx_sixteen_strobes", strobe_count - base, 16);
    check("tx_overflow_sticky", bus.tx_overflow, 1);
    bus.clr_errors = 1;
    tick();
    bus.clr_errors = 0;
    check("tx_overflow_cleared", bus.tx_overflow, 0);

    // RX: single-byte capture table
    for (int v = 0; v < 6; v++) begin
      bus.uart_rxdata = rx_vecs[v].rxdata;
      bus.uart_status = rx_vecs[v].status;
      bus.uart_rx_valid = 1;
      tick();
      bus.uart_rx_valid = 0;
      check($sformatf("rx%0d_read_rx", v), bus.uart_read_rx, 1);
      check($sformatf("rx%0d_count", v), bus.rx_count, 1);
      check($sformatf("rx%0d_data", v), bus.cpu_rd_data, rx_vecs[v].exp_data);
      check($sformatf("rx%0d_status", v), bus.cpu_rd_status, rx_vecs[v].exp_status);
      tick();
      check($sformatf("rx%0d_read_rx_low", v), bus.uart_read_rx, 0);
      bus.cpu_rd = 1;
      tick();
      bus.cpu_rd = 0;
      check($sformatf("rx%0d_empty_after_pop", v), bus.rx_empty, 1);
      check($sformatf("rx%0d_fsm_idle", v), rx_fsm_state, 0);
    end
    check("rx_no_underflow", bus.rx_underflow, 0);

    // RX: fill to full with rx_valid held, UART presents a new byte after each read_rx
    bus.uart_status = 8'h00;
    next_rx = 8'h80;
    bus.uart_rxdata = next_rx;
    bus.uart_rx_valid = 1;
    for (int i = 0; i < 100 && bus.rx_count != 16; i++) begin
      tick();
      if (bus.uart_read_rx) begin
        rx_exp_q.push_back(bus.uart_rxdata);
        next_rx = next_rx + 8'd1;
        bus.uart_rxdata = next_rx;
      end
    end
    check("rx_fill_count", bus.rx_count, 16);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.uart_read_rx) seen++;
    end
    check("rx_full_no_read", seen, 0);
    check("rx_full_count_held", bus.rx_count, 16);
    check("rx_full_head", bus.cpu_rd_data, rx_exp_q[0]);
    bus.cpu_rd = 1;
    void'(rx_exp_q.pop_front());
    tick();
    bus.cpu_rd = 0;
    check("rx_pop_pre_refill", bus.rx_count, 15);
    seen = 0;
    for (int i = 0; i < 2 && seen == 0; i++) begin
      tick();
      if (bus.uart_read_rx) begin
        seen++;
        rx_exp_q.push_back(bus.uart_rxdata);
      end
    end
    bus.uart_rx_valid = 0;
    check("rx_refill_read_rx", seen, 1);
    check("rx_refill_count", bus.rx_count, 16);
    for (int i = 0; i < DEPTH; i++) begin
      if (rx_exp_q.size() > 0) check("rx_drain_data", bus.cpu_rd_data, rx_exp_q.pop_front());
      bus.cpu_rd = 1;
      tick();
    end
    bus.cpu_rd = 0;
    check("rx_drain_empty", bus.rx_empty, 1);
    check("rx_drain_underflow", bus.rx_underflow, 0);

    // RX underflow and clear-vs-new-error priority
    bus.cpu_rd = 1;
    tick();
    bus.cpu_rd = 0;
    check("rx_underflow_set", bus.rx_underflow, 1);
    check("rx_underflow_count", bus.rx_count, 0);
    bus.cpu_rd = 1; bus.clr_errors = 1;
    tick();
    bus.cpu_rd = 0;
    check("rx_underflow_wins", bus.rx_underflow, 1);
    tick();
    bus.clr_errors = 0;
    check("rx_underflow_cleared", bus.rx_underflow, 0);
    check("tx_overflow_unaffected", bus.tx_overflow, 0);

    // Reset during a write strobe with bytes still queued
    bus.uart_tx_empty = 0;
    for (int i = 0; i < 5; i++) begin
      bus.cpu_wr = 1; bus.cpu_wr_data = 8'(8'hE0 + i);
      exp_q.push_back(8'(8'hE0 + i));
      tick();
    end
    bus.cpu_wr = 0;
    bus.uart_tx_empty = 1;
    for (int i = 0; i < 5 && !bus.uart_write_tx; i++) tick();
    check("rst_mid_strobe_seen", bus.uart_write_tx, 1);
    check("rst_mid_count_before", bus.tx_count, 4);
    reset = 1;
    tick();
    reset = 0;
    exp_q.delete();
    base = strobe_count;
    check("rst_mid_write_tx", bus.uart_write_tx, 0);
    check("rst_mid_tx_count", bus.tx_count, 0);
    check("rst_mid_fsm_idle", tx_fsm_state, 0);
    check("rst_mid_txdata", bus.uart_txdata, 0);
    for (int i = 0; i < 20; i++) tick();
    check("rst_mid_no_strobes", strobe_count - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
